// File: rtl/note_picker_if.sv
// Correlator-bank score bus into the note picker, plus the per-frame decision outputs.
// The source side drives scores and strobes; the picker drives the registered results.
interface note_picker_if #(
    parameter int N_NOTES = 5,
    parameter int DW      = 42
);
    logic [N_NOTES*DW-1:0] dot_products;
    logic [N_NOTES-1:0]    dot_product_valid;
    logic                  frame_done;
    logic [3:0]            best_index;
    logic [DW-1:0]         best_score;
    logic [3:0]            note_index;
    logic                  note_valid;

    modport master (
        output dot_products, dot_product_valid,
        input  frame_done, best_index, best_score, note_index, note_valid
    );

    modport slave (
        input  dot_products, dot_product_valid,
        output frame_done, best_index, best_score, note_index, note_valid
    );
endinterface

// File: rtl/note_picker.sv
// Sequential argmax over per-note dot products, threshold, then HOLD-frame debounce of the detected note.
// Latency: N_NOTES+2 cycles from the strobe completing a frame to frame_done; all outputs registered.
// No backpressure: strobes are always accepted, and a repeat strobe before snapshot overwrites that note.
module note_picker #(
    parameter int             N_NOTES = 5,
    parameter int             DW      = 42,
    parameter logic [DW-1:0]  THRESH  = DW'(1_000_000),
    parameter int             HOLD    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    note_picker_if.slave bus
);
    localparam logic [3:0] NONE     = 4'hF;
    localparam logic [3:0] LAST_IDX = 4'(N_NOTES - 1);
    localparam logic [3:0] HOLD_CNT = 4'(HOLD);

    typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;
    state_t state_q, state_d;

    logic [DW-1:0]      cap  [N_NOTES];
    logic [DW-1:0]      snap [N_NOTES];
    logic [N_NOTES-1:0] got;
    logic [3:0]         idx;
    logic [3:0]         bidx;
    logic [DW-1:0]      best;
    logic [DW-1:0]      cur;
    logic               frame_start;

    logic [3:0]         last_vote;
    logic [3:0]         cnt;
    logic [3:0]         vote;
    logic [3:0]         cnt_upd;
    logic [4:0]         cnt_sum;

    logic               frame_done_r;
    logic [3:0]         best_index_r;
    logic [DW-1:0]      best_score_r;
    logic [3:0]         note_index_r;
    logic               note_valid_r;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (&got) begin
                    frame_start = 1'b1;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (idx == LAST_IDX) state_d = DECIDE;
            end
            DECIDE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- capture ----------------
    // A strobe landing on the snapshot edge survives the clear and seeds the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            got <= '0;
            for (int i = 0; i < N_NOTES; i++) cap[i] <= '0;
        end else begin
            got <= (frame_start ? '0 : got) | bus.dot_product_valid;
            for (int i = 0; i < N_NOTES; i++)
                if (bus.dot_product_valid[i]) cap[i] <= bus.dot_products[i*DW +: DW];
        end
    end

    // ---------------- scan ----------------
    always_comb begin
        cur = '0;
        for (int i = 0; i < N_NOTES; i++)
            if (idx == 4'(i)) cur = snap[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NOTES; i++) snap[i] <= '0;
            idx  <= '0;
            best <= '0;
            bidx <= '0;
        end else if (frame_start) begin
            snap <= cap;
            idx  <= '0;
            best <= '0;
            bidx <= '0;
        end else if (state_q == SCAN) begin
            // Strict compare keeps the lowest index on ties.
            if (cur > best) begin
                best <= cur;
                bidx <= idx;
            end
            idx <= idx + 4'd1;
        end
    end

    // ---------------- decide / debounce ----------------
    always_comb begin
        vote    = (best >= THRESH) ? bidx : NONE;
        cnt_sum = {1'b0, cnt} + 5'd1;
        if (vote == last_vote)
            cnt_upd = (cnt_sum > {1'b0, HOLD_CNT}) ? HOLD_CNT : cnt_sum[3:0];
        else
            cnt_upd = 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_r <= 1'b0;
            note_valid_r <= 1'b0;
            best_index_r <= NONE;
            best_score_r <= '0;
            note_index_r <= NONE;
            last_vote    <= NONE;
            cnt          <= '0;
        end else begin
            frame_done_r <= 1'b0;
            note_valid_r <= 1'b0;
            if (state_q == DECIDE) begin
                frame_done_r <= 1'b1;
                best_index_r <= vote;
                best_score_r <= best;
                last_vote    <= vote;
                cnt          <= cnt_upd;
                if (cnt_upd == HOLD_CNT && vote != note_index_r) begin
                    note_index_r <= vote;
                    note_valid_r <= 1'b1;
                end
            end
        end
    end

    assign bus.frame_done = frame_done_r;
    assign bus.best_index = best_index_r;
    assign bus.best_score = best_score_r;
    assign bus.note_index = note_index_r;
    assign bus.note_valid = note_valid_r;
endmodule

// File: tb/tb_note_picker.sv
// Directed bench for note_picker: expected frame decisions are queued at stimulus time
// and a negedge monitor pops and compares them whenever frame_done is seen.
module tb_note_picker;
    localparam int N  = 5;
    localparam int DW = 42;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [3:0]    bi;
        logic [DW-1:0] bs;
        logic [3:0]    ni;
        logic          nv;
        int            at;
    } exp_t;
    exp_t expq[$];

    note_picker_if #(.N_NOTES(N), .DW(DW)) bus();

    note_picker #(.N_NOTES(N), .DW(DW), .THRESH(42'd1_000_000), .HOLD(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (bus.frame_done) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_done: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = expq.pop_front();
                check("done_cycle", cyc, e.at);
                check("best_index", bus.best_index, e.bi);
                check("best_score", bus.best_score, e.bs);
                check("note_index", bus.note_index, e.ni);
                check("note_valid", bus.note_valid, e.nv);
            end
        end else if (bus.note_valid) begin
            checks++;
            errors++;
            $display("FAIL note_valid_alone: got 1 expected 0 (cycle %0d)", cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_scores(input logic [DW-1:0] s0, s1, s2, s3, s4);
        bus.dot_products = {s4, s3, s2, s1, s0};
    endtask

    // Called at posedge+1; strobes for one cycle and returns at the next posedge+1.
    task automatic strobe(input logic [N-1:0] mask);
        bus.dot_product_valid = mask;
        @(posedge clk);
        #1;
        bus.dot_product_valid = '0;
    endtask

    task automatic expect_frame(input logic [3:0] bi, input logic [DW-1:0] bs,
                                input logic [3:0] ni, input logic nv);
        exp_t e;
        e.bi = bi; e.bs = bs; e.ni = ni; e.nv = nv;
        e.at = cyc + 8;
        expq.push_back(e);
    endtask

    task automatic full_frame(input logic [DW-1:0] s0, s1, s2, s3, s4,
                              input logic [3:0] bi, input logic [DW-1:0] bs,
                              input logic [3:0] ni, input logic nv);
        set_scores(s0, s1, s2, s3, s4);
        expect_frame(bi, bs, ni, nv);
        strobe(5'h1F);
        idle(12);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() != 0 && n < 200) begin
            idle(1);
            n++;
        end
        check("pending_decisions", expq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_best_index"}, bus.best_index, 4'hF);
        check({tag, "_best_score"}, bus.best_score, 0);
        check({tag, "_note_index"}, bus.note_index, 4'hF);
        check({tag, "_frame_done"}, bus.frame_done, 0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        set_scores(42'd11, 42'd22, 42'd3_000_000, 42'd44, 42'd55);
        bus.dot_product_valid = 5'h1F;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.dot_product_valid = '0;
        idle(10);
        check_reset_outputs("reset");
        check("reset_note_valid", bus.note_valid, 0);

        // Single-frame argmax, then debounce to note 1; fourth frame gives no pulse.
        full_frame(42'd10, 42'd5_000_000, 42'd2_000_000, 42'd7, 42'd0, 4'd1, 42'd5_000_000, 4'hF, 1'b0);
        full_frame(42'd10, 42'd5_000_000, 42'd2_000_000, 42'd7, 42'd0, 4'd1, 42'd5_000_000, 4'hF, 1'b0);
        full_frame(42'd10, 42'd5_000_000, 42'd2_000_000, 42'd7, 42'd0, 4'd1, 42'd5_000_000, 4'd1, 1'b1);
        full_frame(42'd10, 42'd5_000_000, 42'd2_000_000, 42'd7, 42'd0, 4'd1, 42'd5_000_000, 4'd1, 1'b0);

        // Tie keeps lower index; three ties move the held note to 0.
        full_frame(42'd3_000_000, 42'd3_000_000, 42'd0, 42'd0, 42'd0, 4'd0, 42'd3_000_000, 4'd1, 1'b0);
        full_frame(42'd3_000_000, 42'd3_000_000, 42'd0, 42'd0, 42'd0, 4'd0, 42'd3_000_000, 4'd1, 1'b0);
        full_frame(42'd3_000_000, 42'd3_000_000, 42'd0, 42'd0, 42'd0, 4'd0, 42'd3_000_000, 4'd0, 1'b1);

        // Just below threshold: votes none; three of them release the held note.
        full_frame(42'd999_999, 42'd999_999, 42'd999_999, 42'd999_999, 42'd999_999, 4'hF, 42'd999_999, 4'd0, 1'b0);
        full_frame(42'd999_999, 42'd999_999, 42'd999_999, 42'd999_999, 42'd999_999, 4'hF, 42'd999_999, 4'd0, 1'b0);
        full_frame(42'd999_999, 42'd999_999, 42'd999_999, 42'd999_999, 42'd999_999, 4'hF, 42'd999_999, 4'hF, 1'b1);
        wait_drain();

        // Staggered strobes over 20 cycles; one decision 7 cycles after the last.
        set_scores(42'd100, 42'd200, 42'd1_500_000, 42'd300, 42'd400);
        for (int i = 0; i < N - 1; i++) begin
            strobe(5'(1 << i));
            idle(4);
        end
        expect_frame(4'd2, 42'd1_500_000, 4'hF, 1'b0);
        strobe(5'h10);
        idle(12);
        wait_drain();

        // Note-2 strobe on the snapshot edge belongs to the next frame.
        set_scores(42'd1_200_000, 42'd0, 42'd0, 42'd0, 42'd0);
        expect_frame(4'd0, 42'd1_200_000, 4'hF, 1'b0);
        strobe(5'h1F);
        set_scores(42'd0, 42'd0, 42'd4_000_000, 42'd0, 42'd0);
        strobe(5'h04);
        idle(12);
        wait_drain();
        set_scores(42'd50, 42'd60, 42'd0, 42'd70, 42'd80);
        expect_frame(4'd2, 42'd4_000_000, 4'hF, 1'b0);
        strobe(5'h1B);
        idle(12);
        wait_drain();

        // Reset asserted mid-SCAN aborts the frame with no pulse.
        set_scores(42'd0, 42'd0, 42'd0, 42'd9_000_000, 42'd0);
        strobe(5'h1F);
        idle(2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midscan_reset");
        idle(2);
        rst_n = 1'b1;
        idle(15);
        check_reset_outputs("after_abort");

        // Recovery frame after the abort.
        full_frame(42'd0, 42'd0, 42'd0, 42'd9_000_000, 42'd0, 4'd3, 42'd9_000_000, 4'hF, 1'b0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_picker.md
# note_picker

Downstream of the per-note correlator bank. It collects one 42-bit dot product from each of the N_NOTES correlators per FFT frame and finds the best-matching note with a sequential argmax scan. It then applies an absolute threshold and a multi-frame debounce, and reports a stable detected note (or "none") to the game logic.

## Interface
- N_NOTES, 5, number of correlators/reference notes; legal range 1..15.
- DW, 42, dot-product width.
- THRESH, 42'd1_000_000, minimum winning score for a note to count; a frame below it votes "none".
- HOLD, 3, consecutive identical frame votes required before the stable note changes; legal range 1..15.

Ports (clock and reset first):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- dot_products  in  N_NOTES*DW  packed scores; note i occupies bits [i*DW +: DW].
- dot_product_valid  in  N_NOTES  per-note one-cycle strobe; bit i qualifies slice i.
- frame_done  out  1  one-cycle pulse when a frame's decision is made.
- best_index  out  4  argmax index for the last frame; 4'hF if below THRESH.
- best_score  out  DW  winning score for the last frame.
- note_index  out  4  debounced stable note; 4'hF = none.
- note_valid  out  1  one-cycle pulse when note_index changes.

## Operation
- Capture: on dot_product_valid[i], cap[i] <= slice i and got[i] <= 1. A repeat strobe before the frame completes overwrites cap[i]. It is not an error.
- States: IDLE, SCAN, DECIDE.
- IDLE: when got is all ones, copy cap into snap, clear got, set idx=0, best=0, bidx=0, and go to SCAN.
  - A strobe on the same edge as the clear sets its got bit, because set beats clear. That value belongs to the next frame; snap takes the old cap.
- SCAN: one note per cycle. If snap[idx] > best (strict, unsigned), best <= snap[idx] and bidx <= idx. Ties keep the lower index. After idx = N_NOTES-1, go to DECIDE.
  - Capture stays live during SCAN and DECIDE, so the next frame can accumulate.
- DECIDE: vote = (best >= THRESH) ? bidx : 4'hF.
  - If vote == last_vote, cnt <= sat(cnt+1, HOLD); else last_vote <= vote and cnt <= 1.
  - If the updated cnt == HOLD and vote != note_index: note_index <= vote and note_valid pulses.
  - Always: best_index <= vote, best_score <= best, frame_done pulses. Return to IDLE.
- "None" debounces like any note: HOLD below-threshold frames are required to release a held note.
- Reset values: state IDLE, got=0, cap/snap=0, best_index=4'hF, best_score=0, note_index=4'hF, last_vote=4'hF, cnt=0, frame_done=0, note_valid=0.
- Reset asserted mid-SCAN or mid-DECIDE aborts the frame with no output pulse. The debounce history is lost.

## Timing
- All outputs are registered.
- Edge E0 samples the strobe that completes got.
- E1: snapshot, enter SCAN.
- E2..E(N_NOTES+1): scan.
- E(N_NOTES+2): DECIDE. frame_done, best_index, best_score and any note_valid/note_index change are visible after this edge. Latency is N_NOTES+2 cycles (7 at default).
- Minimum frame spacing is N_NOTES+3 cycles. Frames that complete faster are merged: last write wins per note and one decision is made. Correlator frames are hundreds of cycles apart, so this is unconstrained in practice.
- Strobes for different notes may arrive on the same cycle or on different cycles; completion is order-independent.
- note_valid never pulses without frame_done on the same cycle.

## Test plan
- Reset: hold rst_n=0 with strobes active, release. Required: outputs hold reset values and no pulse appears until a complete frame arrives.
- Single frame argmax: scores {10, 5_000_000, 2_000_000, 7, 0}, all strobes on one cycle. Required:
  - frame_done exactly 7 cycles later.
  - best_index=1, best_score=5_000_000.
  - note_index stays 4'hF.
- Debounce: three identical frames as above. Required: note_valid pulses only on the third frame_done, with note_index=1. A fourth identical frame gives no pulse.
- Tie and threshold:
  - Scores {3M, 3M, 0, 0, 0}: required best_index=0.
  - Then three frames all 999_999 after note 0 is held: required best_index=4'hF each time. note_index goes to 4'hF with a note_valid pulse on the third frame.
- Staggered strobes and overlap:
  - Strobes for notes 0..4 spread over 20 cycles: one decision, made 7 cycles after the last strobe.
  - A note-2 strobe on the snapshot edge: excluded from the current frame and counted in the next.
- Reset mid-SCAN: assert rst_n low 3 cycles after the completing strobe. Required: no frame_done, and all outputs return to reset values.
